// File: rtl/ram_burst_pkg.sv
// Shared types for the RAM burst master: op encodings, FSM states, default widths.
package ram_burst_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_FILL = 2'b00,
    OP_COPY = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_COPY  = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // A command that completes immediately without touching the RAM.
  function automatic logic op_is_noop(input op_e op, input logic len_zero);
    return (op == OP_RSVD) || len_zero;
  endfunction

endpackage

// File: rtl/ram_burst_fifo.sv
// Small synchronous FIFO buffering READ-stream bytes; head entry is presented directly.
module ram_burst_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Qualify push/pop; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    pop_ok_s  = pop && (count_r != '0);
    push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/ram_burst_master.sv
// Single-command burst initiator for the dual-port byte RAM: FILL, COPY and
// a flow-controlled READ stream buffered through ram_burst_fifo.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_wradd,
  output logic [ADDR_W-1:0] ram_rdadd,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_e            state_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic [ADDR_W-1:0] wr_cnt_r;
  logic [ADDR_W-1:0] wradd_r;
  logic [ADDR_W-1:0] rdadd_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              cmd_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              ram_we_r;
  logic              copy_pass_r;
  logic              inflight_r;
  logic              inflight_last_r;
  logic              push_pend_r;
  logic              push_last_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W:0]   fifo_head_s;
  logic              rd_valid_s;
  logic              pop_s;
  logic [OCC_W-1:0]  occ_s;
  logic              issue_ok_s;
  op_e               op_s;

  assign op_s = op_e'(cmd_op);

  // Read-stream flow control: a new read may issue only if its byte is sure to
  // find room when it lands two cycles later.
  always_comb begin
    rd_valid_s = (fifo_count_s != '0);
    pop_s      = rd_valid_s && rd_ready;
    occ_s      = OCC_W'(fifo_count_s) + OCC_W'(push_pend_r) + OCC_W'(inflight_r) - OCC_W'(pop_s);
    if ((state_r == ST_READ) && (rd_cnt_r != len_r)) begin
      issue_ok_s = (occ_s < OCC_W'(FIFO_DEPTH));
    end else begin
      issue_ok_s = 1'b0;
    end
  end

  ram_burst_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_pend_r),
    .push_data ({push_last_r, ram_rd_data}),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s)
  );

  // Command FSM with all RAM-side and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      len_r           <= '0;
      dst_r           <= '0;
      rd_cnt_r        <= '0;
      wr_cnt_r        <= '0;
      wradd_r         <= '0;
      rdadd_r         <= '0;
      wr_data_r       <= '0;
      cmd_ready_r     <= 1'b1;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      ram_we_r        <= 1'b0;
      copy_pass_r     <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      push_pend_r     <= 1'b0;
      push_last_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            len_r    <= cmd_len;
            dst_r    <= cmd_dst;
            rd_cnt_r <= '0;
            wr_cnt_r <= '0;
            if (op_is_noop(op_s, cmd_len == '0)) begin
              done_r <= 1'b1;
            end else begin
              busy_r      <= 1'b1;
              cmd_ready_r <= 1'b0;
              case (op_s)
                OP_FILL: begin
                  state_r     <= ST_FILL;
                  ram_we_r    <= 1'b1;
                  wradd_r     <= cmd_dst;
                  wr_data_r   <= cmd_fill;
                  wr_cnt_r    <= ADDR_W'(1);
                  copy_pass_r <= 1'b0;
                end
                OP_COPY: begin
                  state_r     <= ST_COPY;
                  rdadd_r     <= cmd_src;
                  rd_cnt_r    <= ADDR_W'(1);
                  copy_pass_r <= 1'b1;
                end
                OP_READ: begin
                  state_r         <= ST_READ;
                  rdadd_r         <= cmd_src;
                  rd_cnt_r        <= ADDR_W'(1);
                  inflight_r      <= 1'b1;
                  inflight_last_r <= (cmd_len == ADDR_W'(1));
                end
                default: begin
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  done_r      <= 1'b1;
                end
              endcase
            end
          end
        end

        ST_FILL: begin
          if (wr_cnt_r == len_r) begin
            state_r     <= ST_IDLE;
            ram_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            wradd_r  <= wradd_r + ADDR_W'(1);
            wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
          end
        end

        // Each cycle writes the byte read one cycle earlier; the first write goes to dst.
        ST_COPY: begin
          ram_we_r <= 1'b1;
          wradd_r  <= (wr_cnt_r == '0) ? dst_r : wradd_r + ADDR_W'(1);
          wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
          if (rd_cnt_r == len_r) begin
            state_r <= ST_FLUSH;
          end else begin
            rdadd_r  <= rdadd_r + ADDR_W'(1);
            rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
          end
        end

        ST_FLUSH: begin
          if (wr_cnt_r == len_r) begin
            state_r     <= ST_IDLE;
            ram_we_r    <= 1'b0;
            copy_pass_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            ram_we_r <= 1'b1;
            wradd_r  <= wradd_r + ADDR_W'(1);
            wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
          end
        end

        ST_READ: begin
          push_pend_r <= inflight_r;
          push_last_r <= inflight_last_r;
          if (issue_ok_s) begin
            rdadd_r         <= rdadd_r + ADDR_W'(1);
            rd_cnt_r        <= rd_cnt_r + ADDR_W'(1);
            inflight_r      <= 1'b1;
            inflight_last_r <= (rd_cnt_r == len_r - ADDR_W'(1));
          end else begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
          end
          if (pop_s && fifo_head_s[DATA_W]) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            state_r <= ST_READ;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          ram_we_r    <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // During COPY the write data is the RAM read port, which is only valid in the write cycle.
  assign ram_wr_data = copy_pass_r ? ram_rd_data : wr_data_r;
  assign ram_we      = ram_we_r;
  assign ram_wradd   = wradd_r;
  assign ram_rdadd   = rdadd_r;
  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign rd_valid    = rd_valid_s;
  assign rd_data     = fifo_head_s[DATA_W-1:0];
  assign rd_last     = rd_valid_s && fifo_head_s[DATA_W];

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a write-through byte RAM model.
module tb_ram_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_fill;
  logic        ram_we;
  logic [7:0]  ram_wr_data;
  logic [15:0] ram_wradd;
  logic [15:0] ram_rdadd;
  logic [7:0]  ram_rd_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_ready;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  got_data [8];
  logic        got_last [8];
  int          got_n;

  always #5 clk = ~clk;

  ram_burst_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_fill(cmd_fill), .ram_we(ram_we), .ram_wr_data(ram_wr_data),
    .ram_wradd(ram_wradd), .ram_rdadd(ram_rdadd), .ram_rd_data(ram_rd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .done(done)
  );

  // Dual-port RAM with registered read and same-address write-through.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wradd] <= ram_wr_data;
    ram_rd_data <= (ram_we && (ram_wradd == ram_rdadd)) ? ram_wr_data : mem[ram_rdadd];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input logic [7:0] fill);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill;
    cmd_valid = 1'b1;
    check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 64) begin
      step();
      cyc++;
    end
    check_eq("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic collect_read(input logic [15:0] rdy_pat);
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    logic       last_seen;
    got_n = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0; last_seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      rd_ready = (k < 16) ? rdy_pat[k] : 1'b1;
      if (prev_stall) begin
        check_eq("stall_valid", {31'd0, rd_valid}, 32'd1);
        check_eq("stall_data", {24'd0, rd_data}, {24'd0, prev_d});
        check_eq("stall_last", {31'd0, rd_last}, {31'd0, prev_l});
      end
      if (last_seen) begin
        check_eq("done_after_last", {31'd0, done}, 32'd1);
        break;
      end
      if (done) check_eq("done_early", {31'd0, done}, 32'd0);
      if (rd_valid && rd_ready) begin
        if (got_n < 8) begin
          got_data[got_n] = rd_data;
          got_last[got_n] = rd_last;
        end
        got_n++;
        if (rd_last) last_seen = 1'b1;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_d = rd_data;
      prev_l = rd_last;
      step();
    end
    check_eq("rd_last_seen", {31'd0, last_seen}, 32'd1);
    rd_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [15:0] prev_rd;
    logic [15:0] prev_wr;
    logic [7:0]  exp_b [4];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 16'h0000;
    cmd_dst = 16'h0000; cmd_len = 16'h0000; cmd_fill = 8'h00; rd_ready = 1'b1;
    step(); step(); step();
    check_eq("rst_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rd_last", {31'd0, rd_last}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wradd", {16'd0, ram_wradd}, 32'd0);
    check_eq("rst_rdadd", {16'd0, ram_rdadd}, 32'd0);
    check_eq("rst_wr_data", {24'd0, ram_wr_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // FILL dst=0x10 len=4 fill=A5: writes t+1..t+4, done t+5
    issue(2'b00, 16'h0000, 16'h0010, 16'd4, 8'hA5);
    check_eq("fill_busy", {31'd0, busy}, 32'd1);
    check_eq("fill_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_we", {31'd0, ram_we}, 32'd1);
      check_eq("fill_wradd", {16'd0, ram_wradd}, 32'h10 + i);
      check_eq("fill_wdata", {24'd0, ram_wr_data}, 32'hA5);
      check_eq("fill_no_done", {31'd0, done}, 32'd0);
      step();
    end
    check_eq("fill_done", {31'd0, done}, 32'd1);
    check_eq("fill_we_off", {31'd0, ram_we}, 32'd0);
    check_eq("fill_busy_off", {31'd0, busy}, 32'd0);
    step();
    check_eq("fill_done_pulse", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) check_eq("fill_mem", {24'd0, mem[16'h10 + i]}, 32'hA5);

    // READ the filled range back
    issue(2'b10, 16'h0010, 16'h0000, 16'd4, 8'h00);
    check_eq("read_valid_t1", {31'd0, rd_valid}, 32'd0);
    check_eq("read_we_t1", {31'd0, ram_we}, 32'd0);
    step();
    check_eq("read_valid_t2", {31'd0, rd_valid}, 32'd0);
    collect_read(16'hFFFF);
    check_eq("read_count", got_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("read_data", {24'd0, got_data[i]}, 32'hA5);
      check_eq("read_last", {31'd0, got_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    step();

    // COPY 0x100 -> 0x200 len 3
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h00;
    issue(2'b01, 16'h0100, 16'h0200, 16'd3, 8'h00);
    check_eq("copy_rdadd_t1", {16'd0, ram_rdadd}, 32'h100);
    check_eq("copy_we_t1", {31'd0, ram_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("copy_we", {31'd0, ram_we}, 32'd1);
      check_eq("copy_wradd", {16'd0, ram_wradd}, 32'h200 + i);
      check_eq("copy_wdata", {24'd0, ram_wr_data}, {24'd0, exp_b[i]});
      if (i < 2) check_eq("copy_rdadd", {16'd0, ram_rdadd}, 32'h101 + i);
    end
    step();
    check_eq("copy_done_t5", {31'd0, done}, 32'd1);
    check_eq("copy_we_off", {31'd0, ram_we}, 32'd0);
    for (int i = 0; i < 3; i++) check_eq("copy_mem", {24'd0, mem[16'h200 + i]}, {24'd0, exp_b[i]});
    step();

    // Overlapping COPY 0x40 -> 0x41 len 4 replicates mem[0x40]
    mem[16'h0040] = 8'h7E;
    for (int i = 1; i < 5; i++) mem[16'h0040 + i] = 8'(i);
    issue(2'b01, 16'h0040, 16'h0041, 16'd4, 8'h00);
    wait_done(cyc);
    check_eq("ovl_latency", cyc, 32'd6);
    for (int i = 1; i < 5; i++) check_eq("ovl_mem", {24'd0, mem[16'h0040 + i]}, 32'h7E);
    step();

    // Wrapping READ with backpressure
    mem[16'hFFFE] = 8'hC1; mem[16'hFFFF] = 8'hC2; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hC4;
    exp_b[0] = 8'hC1; exp_b[1] = 8'hC2; exp_b[2] = 8'hC3; exp_b[3] = 8'hC4;
    issue(2'b10, 16'hFFFE, 16'h0000, 16'd4, 8'h00);
    collect_read(16'b1111_1111_1101_1001);
    check_eq("wrap_count", got_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_data", {24'd0, got_data[i]}, {24'd0, exp_b[i]});
      check_eq("wrap_last", {31'd0, got_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    step();

    // Zero length and reserved op complete immediately without RAM access
    prev_rd = ram_rdadd; prev_wr = ram_wradd;
    issue(2'b00, 16'h0000, 16'h0123, 16'd0, 8'h77);
    check_eq("len0_done", {31'd0, done}, 32'd1);
    check_eq("len0_we", {31'd0, ram_we}, 32'd0);
    check_eq("len0_rdadd", {16'd0, ram_rdadd}, {16'd0, prev_rd});
    check_eq("len0_wradd", {16'd0, ram_wradd}, {16'd0, prev_wr});
    step();
    check_eq("len0_done_pulse", {31'd0, done}, 32'd0);
    issue(2'b11, 16'h1234, 16'h5678, 16'd5, 8'hFF);
    check_eq("rsvd_done", {31'd0, done}, 32'd1);
    check_eq("rsvd_we", {31'd0, ram_we}, 32'd0);
    check_eq("rsvd_rdadd", {16'd0, ram_rdadd}, {16'd0, prev_rd});
    step();
    check_eq("rsvd_we_after", {31'd0, ram_we}, 32'd0);

    // Reset in the middle of an 8-byte FILL, after three writes
    issue(2'b00, 16'h0000, 16'h0300, 16'd8, 8'h5A);
    step(); step();
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dst = 16'h0500; cmd_len = 16'd2; cmd_fill = 8'hEE;
    step();
    check_eq("rstm_we", {31'd0, ram_we}, 32'd0);
    check_eq("rstm_done", {31'd0, done}, 32'd0);
    check_eq("rstm_busy", {31'd0, busy}, 32'd0);
    step();
    check_eq("rstm_we2", {31'd0, ram_we}, 32'd0);
    check_eq("rstm_done2", {31'd0, done}, 32'd0);
    rst_n = 1'b1; cmd_valid = 1'b0;
    step();
    check_eq("rstm_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rstm_done3", {31'd0, done}, 32'd0);
    check_eq("rstm_we3", {31'd0, ram_we}, 32'd0);
    check_eq("rstm_mem_last", {24'd0, mem[16'h0302]}, 32'h5A);
    check_eq("rstm_mem_stop", {24'd0, mem[16'h0303]}, 32'h00);
    check_eq("rstm_mem_ignored", {24'd0, mem[16'h0500]}, 32'h00);
    issue(2'b00, 16'h0000, 16'h0400, 16'd2, 8'h3C);
    wait_done(cyc);
    check_eq("post_rst_latency", cyc, 32'd3);
    check_eq("post_rst_mem0", {24'd0, mem[16'h0400]}, 32'h3C);
    check_eq("post_rst_mem1", {24'd0, mem[16'h0401]}, 32'h3C);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
